// File: rtl/riscv_mem_wb_hazard.sv
// Memory, write-back and load-use hazard slice of the word-addressed RV32I pipeline.
// Holds the data RAM with func3 store lanes, load extension, the WB source mux and the stall detector.
module riscv_mem_wb_hazard #(
  parameter int ADDR_WIDTH   = 8,
  parameter int DATA_WIDTH   = 32,
  parameter int CONSOLE_ADDR = 255
) (
  input  logic                  clock,
  input  logic                  clear,
  input  logic [ADDR_WIDTH-1:0] mem_addr,
  input  logic [DATA_WIDTH-1:0] mem_din,
  input  logic                  mem_wren,
  input  logic [2:0]            mem_func3,
  output logic [DATA_WIDTH-1:0] dmem_out,
  input  logic                  wb_mem_to_reg,
  input  logic                  wb_offset_to_reg,
  input  logic [DATA_WIDTH-1:0] wb_dmem_out,
  input  logic [DATA_WIDTH-1:0] wb_alu_result,
  input  logic [DATA_WIDTH-1:0] wb_branch_addr,
  input  logic [DATA_WIDTH-1:0] wb_next_pc,
  output logic [DATA_WIDTH-1:0] data_d,
  output logic [9:0]            ledr,
  input  logic                  ex_mem_read,
  input  logic [4:0]            id_rs1,
  input  logic [4:0]            id_rs2,
  input  logic [4:0]            ex_rd,
  output logic                  not_stall,
  output logic [7:0]            console_char
);

  localparam int DEPTH = 2 ** ADDR_WIDTH;

  logic [DATA_WIDTH-1:0] ram [0:DEPTH-1];
  logic [DATA_WIDTH-1:0] rawWord;
  logic                  consoleHit;

  // RAM is never reset; only the addressed lanes change so partial stores keep the rest of the word
  always_ff @(posedge clock) begin
    if (mem_wren) begin
      case (mem_func3[1:0])
        2'b00:   ram[mem_addr][7:0]  <= mem_din[7:0];
        2'b01:   ram[mem_addr][15:0] <= mem_din[15:0];
        default: ram[mem_addr]       <= mem_din;
      endcase
    end
  end

  assign rawWord    = ram[mem_addr];
  assign consoleHit = (mem_addr == ADDR_WIDTH'(CONSOLE_ADDR));

  // Console captures the low byte of any store to its address, whatever the store width
  always_ff @(posedge clock or negedge clear) begin
    if (!clear) begin
      console_char <= 8'h00;
    end else if (mem_wren && consoleHit) begin
      console_char <= mem_din[7:0];
    end
  end

  always_comb begin
    dmem_out = rawWord;
    case (mem_func3)
      3'b000:  dmem_out = {{(DATA_WIDTH-8){rawWord[7]}}, rawWord[7:0]};
      3'b001:  dmem_out = {{(DATA_WIDTH-16){rawWord[15]}}, rawWord[15:0]};
      3'b100:  dmem_out = {{(DATA_WIDTH-8){1'b0}}, rawWord[7:0]};
      3'b101:  dmem_out = {{(DATA_WIDTH-16){1'b0}}, rawWord[15:0]};
      default: dmem_out = rawWord;
    endcase
  end

  always_comb begin
    data_d = wb_alu_result;
    case ({wb_offset_to_reg, wb_mem_to_reg})
      2'b00:   data_d = wb_alu_result;
      2'b01:   data_d = wb_dmem_out;
      2'b10:   data_d = wb_next_pc;
      default: data_d = wb_branch_addr;
    endcase
  end

  assign ledr = data_d[9:0];

  // A load in EX whose destination feeds the ID instruction must hold the front end for one cycle
  assign not_stall = !(ex_mem_read && (ex_rd != 5'd0) &&
                       ((ex_rd == id_rs1) || (ex_rd == id_rs2)));

endmodule

// File: tb/tb_riscv_mem_wb_hazard.sv
// Scoreboard bench: stimulus pushes expected outputs, a negedge monitor pops and compares.
module tb_riscv_mem_wb_hazard;

  logic        clock;
  logic        clear;
  logic [7:0]  memAddr;
  logic [31:0] memDin;
  logic        memWren;
  logic [2:0]  memFunc3;
  logic [31:0] dmemOut;
  logic        wbMemToReg;
  logic        wbOffsetToReg;
  logic [31:0] wbDmemOut;
  logic [31:0] wbAluResult;
  logic [31:0] wbBranchAddr;
  logic [31:0] wbNextPc;
  logic [31:0] dataD;
  logic [9:0]  ledr;
  logic        exMemRead;
  logic [4:0]  idRs1;
  logic [4:0]  idRs2;
  logic [4:0]  exRd;
  logic        notStall;
  logic [7:0]  consoleChar;

  riscv_mem_wb_hazard dut (
    .clock(clock), .clear(clear),
    .mem_addr(memAddr), .mem_din(memDin), .mem_wren(memWren), .mem_func3(memFunc3),
    .dmem_out(dmemOut),
    .wb_mem_to_reg(wbMemToReg), .wb_offset_to_reg(wbOffsetToReg),
    .wb_dmem_out(wbDmemOut), .wb_alu_result(wbAluResult),
    .wb_branch_addr(wbBranchAddr), .wb_next_pc(wbNextPc),
    .data_d(dataD), .ledr(ledr),
    .ex_mem_read(exMemRead), .id_rs1(idRs1), .id_rs2(idRs2), .ex_rd(exRd),
    .not_stall(notStall), .console_char(consoleChar)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  typedef struct {
    logic        clr;
    logic [7:0]  addr;
    logic [31:0] din;
    logic        wren;
    logic [2:0]  f3;
    logic        m2r;
    logic        off;
    logic [31:0] wbDmem;
    logic [31:0] alu;
    logic [31:0] br;
    logic [31:0] npc;
    logic        emr;
    logic [4:0]  rs1;
    logic [4:0]  rs2;
    logic [4:0]  rd;
  } stim_t;

  typedef struct {
    bit          chkDmem;
    logic [31:0] dmem;
    logic [31:0] dataD;
    logic        ns;
    logic [7:0]  con;
  } exp_t;

  exp_t        expQ[$];
  exp_t        cur;
  int          checks = 0;
  int          errors = 0;
  logic [31:0] modelMem [256];
  bit          known [256];
  logic [7:0]  modelCon;

  function automatic logic [31:0] loadModel(logic [31:0] raw, logic [2:0] f3);
    logic [31:0] b;
    logic [31:0] h;
    b = raw % 256;
    h = raw % 65536;
    case (f3)
      3'd0: return (b >= 128) ? b + 32'hFFFF_FF00 : b;
      3'd1: return (h >= 32768) ? h + 32'hFFFF_0000 : h;
      3'd4: return b;
      3'd5: return h;
      default: return raw;
    endcase
  endfunction

  function automatic stim_t randStim();
    stim_t s;
    s.clr = 1'b1;
    s.addr = 8'($urandom);
    s.din = $urandom;
    s.wren = 1'b0;
    s.f3 = 3'($urandom);
    s.m2r = 1'($urandom);
    s.off = 1'($urandom);
    s.wbDmem = $urandom;
    s.alu = $urandom;
    s.br = $urandom;
    s.npc = $urandom;
    s.emr = 1'($urandom);
    s.rs1 = 5'($urandom_range(0, 3));
    s.rs2 = 5'($urandom_range(0, 3));
    s.rd = 5'($urandom_range(0, 3));
    return s;
  endfunction

  // Drives one cycle of inputs, queues the expected response, then commits the edge into the model
  task automatic applyStimulus(input stim_t s);
    exp_t e;
    logic [31:0] srcs [4];
    @(posedge clock);
    #1;
    clear = s.clr; memAddr = s.addr; memDin = s.din; memWren = s.wren; memFunc3 = s.f3;
    wbMemToReg = s.m2r; wbOffsetToReg = s.off; wbDmemOut = s.wbDmem; wbAluResult = s.alu;
    wbBranchAddr = s.br; wbNextPc = s.npc;
    exMemRead = s.emr; idRs1 = s.rs1; idRs2 = s.rs2; exRd = s.rd;
    srcs[0] = s.alu; srcs[1] = s.wbDmem; srcs[2] = s.npc; srcs[3] = s.br;
    if (!s.clr) modelCon = 8'h00;
    e.chkDmem = known[s.addr];
    e.dmem = loadModel(modelMem[s.addr], s.f3);
    e.dataD = srcs[s.off * 2 + s.m2r];
    e.ns = !(s.emr && s.rd != 0 && (s.rd == s.rs1 || s.rd == s.rs2));
    e.con = modelCon;
    expQ.push_back(e);
    if (s.wren) begin
      if (s.f3 % 4 == 0)
        modelMem[s.addr] = modelMem[s.addr] - (modelMem[s.addr] % 256) + (s.din % 256);
      else if (s.f3 % 4 == 1)
        modelMem[s.addr] = modelMem[s.addr] - (modelMem[s.addr] % 65536) + (s.din % 65536);
      else begin
        modelMem[s.addr] = s.din;
        known[s.addr] = 1'b1;
      end
      if (s.clr && s.addr == 8'd255) modelCon = s.din[7:0];
    end
  endtask

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("[TB] FAIL %s actual=0x%08h required=0x%08h at %0t", name, act, req, $time);
    end
  endtask

  // Monitor: outputs are settled by the falling edge, so each queued expectation is checked there
  always @(negedge clock) begin
    if (expQ.size() > 0) begin
      cur = expQ.pop_front();
      if (cur.chkDmem) checkOutput("dmem_out", dmemOut, cur.dmem);
      checkOutput("data_d", dataD, cur.dataD);
      checkOutput("ledr", {22'd0, ledr}, {22'd0, cur.dataD[9:0]});
      checkOutput("not_stall", {31'd0, notStall}, {31'd0, cur.ns});
      checkOutput("console_char", {24'd0, consoleChar}, {24'd0, cur.con});
    end
  end

  initial begin
    stim_t s;
    logic [2:0] rdF3 [5];
    rdF3[0] = 3'd2; rdF3[1] = 3'd0; rdF3[2] = 3'd4; rdF3[3] = 3'd1; rdF3[4] = 3'd5;
    for (int i = 0; i < 256; i++) begin
      known[i] = 1'b0;
      modelMem[i] = 32'd0;
    end
    modelCon = 8'h00;
    clear = 1'b0; memAddr = 0; memDin = 0; memWren = 0; memFunc3 = 0;
    wbMemToReg = 0; wbOffsetToReg = 0; wbDmemOut = 0; wbAluResult = 0;
    wbBranchAddr = 0; wbNextPc = 0; exMemRead = 0; idRs1 = 0; idRs2 = 0; exRd = 0;

    s = randStim(); s.clr = 1'b0;
    applyStimulus(s);

    for (int i = 0; i < 256; i++) begin
      s = randStim(); s.addr = 8'(i); s.wren = 1'b1; s.f3 = 3'd2;
      applyStimulus(s);
    end

    s = randStim(); s.addr = 8'd4; s.din = 32'h8000_00F1; s.wren = 1'b1; s.f3 = 3'd2;
    applyStimulus(s);
    for (int i = 0; i < 5; i++) begin
      s = randStim(); s.addr = 8'd4; s.f3 = rdF3[i];
      applyStimulus(s);
    end

    s = randStim(); s.addr = 8'd4; s.din = 32'h1234_5678; s.wren = 1'b1; s.f3 = 3'd2;
    applyStimulus(s);
    s = randStim(); s.addr = 8'd4; s.din = 32'hFFFF_FFAA; s.wren = 1'b1; s.f3 = 3'd0;
    applyStimulus(s);
    s = randStim(); s.addr = 8'd4; s.din = 32'h0000_BEEF; s.wren = 1'b1; s.f3 = 3'd1;
    applyStimulus(s);
    s = randStim(); s.addr = 8'd4; s.f3 = 3'd2;
    applyStimulus(s);
    s = randStim(); s.addr = 8'd4; s.f3 = 3'd1;
    applyStimulus(s);

    s = randStim(); s.addr = 8'd255; s.din = 32'h0000_0048; s.wren = 1'b1; s.f3 = 3'd0;
    applyStimulus(s);
    s = randStim(); s.addr = 8'd255; s.din = 32'h0000_0077;
    applyStimulus(s);
    s = randStim(); s.clr = 1'b0;
    applyStimulus(s);
    s = randStim(); s.addr = 8'd4; s.f3 = 3'd2;
    applyStimulus(s);

    for (int i = 0; i < 4; i++) begin
      s = randStim();
      s.alu = 32'h11; s.wbDmem = 32'h22; s.npc = 32'h33; s.br = 32'h44;
      s.off = 1'(i / 2); s.m2r = 1'(i % 2);
      applyStimulus(s);
    end

    s = randStim(); s.emr = 1; s.rd = 5; s.rs1 = 5; s.rs2 = 1;
    applyStimulus(s);
    s = randStim(); s.emr = 1; s.rd = 5; s.rs1 = 3; s.rs2 = 5;
    applyStimulus(s);
    s = randStim(); s.emr = 1; s.rd = 0; s.rs1 = 0; s.rs2 = 0;
    applyStimulus(s);
    s = randStim(); s.emr = 0; s.rd = 5; s.rs1 = 5; s.rs2 = 5;
    applyStimulus(s);
    s = randStim(); s.emr = 1; s.rd = 7; s.rs1 = 5; s.rs2 = 6;
    applyStimulus(s);

    s = randStim(); s.addr = 8'd0; s.din = 32'hA5A5_0001; s.wren = 1'b1; s.f3 = 3'd2;
    applyStimulus(s);
    s = randStim(); s.addr = 8'd255; s.din = 32'h5A5A_00FF; s.wren = 1'b1; s.f3 = 3'd3;
    applyStimulus(s);
    for (int i = 0; i < 4; i++) begin
      s = randStim(); s.f3 = 3'd2;
      s.addr = (i == 0) ? 8'd0 : (i == 1) ? 8'd255 : (i == 2) ? 8'd1 : 8'd254;
      applyStimulus(s);
    end

    for (int i = 0; i < 600; i++) begin
      s = randStim();
      s.wren = 1'($urandom_range(0, 1));
      if ($urandom_range(0, 7) == 0) s.addr = 8'd255;
      if ($urandom_range(0, 49) == 0) s.clr = 1'b0;
      applyStimulus(s);
    end

    for (int i = 0; i < 20 && expQ.size() > 0; i++) @(negedge clock);
    #1;
    if (expQ.size() > 0) begin
      checks++;
      errors++;
      $display("[TB] FAIL scoreboard_drain actual=%0d pending required=0", expQ.size());
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
